// File: rtl/data_mem_mmio_pkg.sv
// Shared constants and types for the data-side memory / MMIO responder.
package data_mem_mmio_pkg;

  // Addr[31:16] value that selects the peripheral window.
  localparam logic [15:0] MMIO_TAG_DEFAULT = 16'hFFFF;

  // Register offsets within the window (Addr[7:0]).
  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_GPIO   = 8'h04;
  localparam logic [7:0] OFF_LOAD   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  // Bit positions inside the STATUS register.
  localparam int STATUS_EXPIRED_BIT = 0;
  localparam int STATUS_RUNNING_BIT = 1;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/data_mem_mmio_timer.sv
// One-shot countdown timer with a sticky expiry flag.
module mmio_timer
  import data_mem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_we,
  input  logic [31:0] load_val,
  input  logic        clr_we,
  input  logic        clr_bit,
  output logic        running,
  output logic        expired
);

  timer_state_t state, state_next;
  logic [31:0]  count, count_next;
  logic         expired_next;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state   <= T_IDLE;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      expired <= expired_next;
    end
  end

  // Next-state logic: clear, then countdown/expiry, then LOAD overrides.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    count_next   = count;
    expired_next = expired;

    if (clr_we && clr_bit) begin
      expired_next = 1'b0;
    end

    // Expiry is evaluated after the clear so that a coinciding set wins.
    if (state == T_RUN) begin
      count_next = count - 32'd1;
      if (count == 32'd1) begin
        expired_next = 1'b1;
        state_next   = T_IDLE;
      end
    end

    // A LOAD write replaces whatever the old countdown would have done.
    if (load_we) begin
      if (load_val != 32'd0) begin
        count_next   = load_val;
        state_next   = T_RUN;
        expired_next = expired && !(clr_we && clr_bit);
      end else begin
        count_next   = count;
        state_next   = T_IDLE;
        expired_next = 1'b1;
      end
    end
  end

  assign running = (state == T_RUN);

endmodule

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM plus a peripheral window (cycle counter, GPIO,
// countdown timer) serving the single-cycle core's load/store port.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [15:0] MMIO_TAG = MMIO_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   cycle;
  logic [7:0]    gpio;
  logic          is_mmio;
  logic [7:0]    offset;
  logic [AW-1:0] ram_idx;
  logic          running;
  logic          expired;
  logic          load_we;
  logic          clr_we;

  // Addr[15:8] plays no part in decoding; folded here to document that.
  logic unused_addr;
  assign unused_addr = ^Addr[15:8];

  assign is_mmio = (Addr[31:16] == MMIO_TAG);
  assign offset  = Addr[7:0];
  assign ram_idx = Addr[AW+1:2];

  assign load_we = MemWrite && is_mmio && (offset == OFF_LOAD);
  assign clr_we  = MemWrite && is_mmio && (offset == OFF_STATUS);

  // RAM write port; contents are left undefined until first written.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto plain memory macros;
    // software must write a word before relying on its value.
    if (MemWrite && !is_mmio) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // Free-running cycle counter and GPIO output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle <= '0;
      gpio  <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (MemWrite && is_mmio && (offset == OFF_GPIO)) begin
        gpio <= WriteData[7:0];
      end
    end
  end

  mmio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_we  (load_we),
    .load_val (WriteData),
    .clr_we   (clr_we),
    .clr_bit  (WriteData[0]),
    .running  (running),
    .expired  (expired)
  );

  // Combinational read mux so loads complete in the same cycle.
  always_comb begin
    ReadData = '0;
    if (is_mmio) begin
      case (offset)
        OFF_CYCLE:  ReadData = cycle;
        OFF_GPIO:   ReadData = {24'b0, gpio};
        OFF_STATUS: begin
          ReadData[STATUS_RUNNING_BIT] = running;
          ReadData[STATUS_EXPIRED_BIT] = expired;
        end
        default:    ReadData = '0;
      endcase
    end else begin
      ReadData = mem[ram_idx];
    end
  end

  assign gpio_out  = gpio;
  assign timer_irq = expired;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: stimulus pushes expectations for the
// current cycle, a negedge monitor pops and compares them.
module tb_data_mem_mmio;

  localparam int DEPTH = 64;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_0004;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  typedef enum int { K_RDATA, K_GPIO, K_IRQ } kind_t;

  typedef struct {
    kind_t       kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  exp_t sb[$];
  int   tests;
  int   fails;

  data_mem_mmio #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: mid-cycle, compare everything expected for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: check(e.name, ReadData, e.exp);
        K_GPIO:  check(e.name, {24'b0, gpio_out}, e.exp);
        default: check(e.name, {31'b0, timer_irq}, e.exp);
      endcase
    end
  end

  task automatic expect_v(input kind_t k, input string name, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.name = name;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] wd);
    reset     = rst;
    MemWrite  = we;
    Addr      = a;
    WriteData = wd;
  endtask

  // End the current cycle and move just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] v);
    drive(1'b1, 1'b0, a, 32'h0);
    expect_v(K_RDATA, name, v);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b1, a, wd);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;

    // Reset held for a few edges; MMIO reads 0 while in reset.
    drive(1'b0, 1'b0, A_CYCLE, 32'h0);
    tick();
    drive(1'b0, 1'b0, A_CYCLE, 32'h0);
    expect_v(K_RDATA, "rst_cycle", 32'h0);
    expect_v(K_GPIO, "rst_gpio", 32'h0);
    expect_v(K_IRQ, "rst_irq", 32'h0);
    tick();
    drive(1'b0, 1'b0, A_STATUS, 32'h0);
    expect_v(K_RDATA, "rst_status", 32'h0);
    tick();

    // Release reset: CYCLE reads 0, 1, then 5.
    rd(A_CYCLE, "cycle_0", 32'd0); tick();
    rd(A_CYCLE, "cycle_1", 32'd1); tick();
    repeat (3) begin rd(32'h0, "idle", 32'hx); void'(sb.pop_back()); tick(); end
    rd(A_CYCLE, "cycle_5", 32'd5); tick();

    // RAM store, readback and aliasing.
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0014, 32'h0BAD_F00D);
    rd(32'h0000_0010, "ram_rd", 32'hDEAD_BEEF); tick();
    rd(32'h0000_0010 + 4 * DEPTH, "ram_alias", 32'hDEAD_BEEF); tick();
    rd(32'h0000_0014, "ram_neighbor", 32'h0BAD_F00D); tick();

    // GPIO write, readback, ignored bits, unmapped and write-only offsets.
    wr(A_GPIO, 32'h1234_56A5);
    rd(A_GPIO, "gpio_rd", 32'h0000_00A5);
    expect_v(K_GPIO, "gpio_out", 32'h0000_00A5);
    tick();
    rd(32'hFFFF_0104, "gpio_alias", 32'h0000_00A5); tick();
    rd(32'hFFFF_0010, "unmapped_rd", 32'h0); tick();
    rd(A_LOAD, "load_rd", 32'h0); tick();
    drive(1'b0, 1'b0, A_GPIO, 32'h0);
    tick();
    rd(A_GPIO, "gpio_after_rst", 32'h0);
    expect_v(K_GPIO, "gpio_out_rst", 32'h0);
    tick();

    // LOAD 3: running for three cycles, then expired.
    wr(A_LOAD, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      rd(A_STATUS, $sformatf("t3_run%0d", i), 32'h2);
      expect_v(K_IRQ, $sformatf("t3_irq_lo%0d", i), 32'h0);
      tick();
    end
    rd(A_STATUS, "t3_expired", 32'h1);
    expect_v(K_IRQ, "t3_irq_hi", 32'h1);
    tick();
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, "t3_cleared", 32'h0);
    expect_v(K_IRQ, "t3_irq_clr", 32'h0);
    tick();

    // Restart: LOAD 5, one idle cycle, LOAD 5 again; expiry follows the second.
    wr(A_LOAD, 32'd5);
    rd(A_STATUS, "r5_first", 32'h2); tick();
    wr(A_LOAD, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      rd(A_STATUS, $sformatf("r5_run%0d", i), 32'h2);
      expect_v(K_IRQ, $sformatf("r5_irq_lo%0d", i), 32'h0);
      tick();
    end
    rd(A_STATUS, "r5_expired", 32'h1);
    expect_v(K_IRQ, "r5_irq_hi", 32'h1);
    tick();

    // Clear coinciding with the expiry edge: set wins.
    wr(A_STATUS, 32'h1);
    wr(A_LOAD, 32'd2);
    rd(A_STATUS, "cc_run", 32'h2); tick();
    drive(1'b1, 1'b1, A_STATUS, 32'h1);
    expect_v(K_IRQ, "cc_irq_before", 32'h0);
    tick();
    rd(A_STATUS, "cc_status", 32'h1);
    expect_v(K_IRQ, "cc_irq_kept", 32'h1);
    tick();

    // LOAD of 0 forces expiry immediately.
    wr(A_STATUS, 32'h1);
    wr(A_LOAD, 32'd0);
    rd(A_STATUS, "load0_status", 32'h1);
    expect_v(K_IRQ, "load0_irq", 32'h1);
    tick();

    // Reset mid-countdown: no expiry is reported afterwards.
    wr(A_STATUS, 32'h1);
    wr(A_LOAD, 32'd10);
    repeat (3) begin rd(A_STATUS, "mid_run", 32'h2); tick(); end
    drive(1'b0, 1'b0, A_STATUS, 32'h0);
    tick();
    rd(A_STATUS, "mid_rst_status", 32'h0);
    tick();
    for (int i = 0; i < 12; i++) begin
      rd(A_STATUS, $sformatf("mid_idle%0d", i), 32'h0);
      expect_v(K_IRQ, $sformatf("mid_irq%0d", i), 32'h0);
      tick();
    end

    // Every pushed expectation must have been consumed by the monitor.
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
